// File: rtl/pwl_slope_table.sv
// pwl_slope_table: piecewise-linear interpolator. Builds a per-segment slope table through an
// external slope generator, then serves a 3-stage interpolation stream. Optional macro: PWL_ROUND_EN.
module pwl_slope_table #(
   parameter int XW         = 8,
   parameter int SEG_BITS   = 4,
   parameter int DSIZE      = 16,
   parameter int DT_I       = 8,
   parameter int DT_D       = 4,
   parameter int GD_LATENCY = 2
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 knot_wr,
   input  logic [SEG_BITS:0]    knot_addr,
   input  logic [DSIZE-1:0]     knot_data,
   input  logic                 build_start,
   output logic                 build_busy,
   output logic                 table_ready,
   output logic                 knot_err,
   output logic [DSIZE-1:0]     gd_y_disp,
   input  logic [DT_I+DT_D-1:0] gd_delta,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XW-1:0]        in_x,
   output logic                 out_valid,
   output logic [DSIZE-1:0]     out_y
);
   localparam int NSEG      = 2**SEG_BITS;
   localparam int FW        = XW - SEG_BITS;
   localparam int DW        = DT_I + DT_D;
   localparam int PW        = DW + FW;
   localparam int BUILD_LEN = NSEG + GD_LATENCY;
   localparam int CW        = $clog2(BUILD_LEN);

   typedef enum logic [1:0] {S_IDLE, S_BUILD, S_RUN} state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic                  r_build_busy;
   logic                  r_table_ready;
   logic                  r_knot_err;
   logic [DSIZE-1:0]      r_knot  [0:NSEG];
   logic [DW-1:0]         r_slope [0:NSEG-1];
   logic                  r_sr_v   [GD_LATENCY];
   logic [SEG_BITS-1:0]   r_sr_idx [GD_LATENCY];

   logic                  r_s1_v;
   logic [SEG_BITS-1:0]   r_s1_seg;
   logic [FW-1:0]         r_s1_frac;
   logic                  r_s2_v;
   logic [DSIZE-1:0]      r_s2_knot;
   logic [PW-1:0]         r_s2_prod;
   logic                  r_out_v;
   logic [DSIZE-1:0]      r_out_y;

   logic                  w_issue;
   logic [SEG_BITS-1:0]   w_iss_idx;
   logic [SEG_BITS:0]     w_iss_nxt;
   logic [DSIZE-1:0]      w_k0;
   logic [DSIZE-1:0]      w_k1;
   logic                  w_mono;
   logic                  w_knot_wr_ok;
   logic                  w_accept;
   logic [PW-1:0]         w_prod;
   logic [PW:0]           w_prod_adj;
   logic [PW:0]           w_inc;
   logic [DSIZE:0]        w_sum;

   assign w_issue      = (r_state == S_BUILD) && (int'(r_cnt) < NSEG);
   assign w_iss_idx    = r_cnt[SEG_BITS-1:0];
   assign w_iss_nxt    = {1'b0, w_iss_idx} + (SEG_BITS+1)'(1);
   assign w_k0         = r_knot[{1'b0, w_iss_idx}];
   assign w_k1         = r_knot[w_iss_nxt];
   assign w_mono       = (w_k1 >= w_k0);
   assign w_knot_wr_ok = knot_wr && (r_state != S_BUILD) && (knot_addr <= (SEG_BITS+1)'(NSEG));
   assign w_accept     = in_valid && r_table_ready;

   // Displacement is combinational off the issue counter so knot writes landing on the
   // build_start edge are already visible to issue index 0.
   assign gd_y_disp    = (w_issue && w_mono) ? (w_k1 - w_k0) : '0;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_build_busy  <= 1'b0;
         r_table_ready <= 1'b0;
         r_knot_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (build_start) begin
                  r_state      <= S_BUILD;
                  r_cnt        <= '0;
                  r_build_busy <= 1'b1;
                  r_knot_err   <= 1'b0;
               end
            end
            S_BUILD: begin
               if (w_issue && !w_mono)
                  r_knot_err <= 1'b1;
               if (int'(r_cnt) == BUILD_LEN - 1) begin
                  r_state       <= S_RUN;
                  r_build_busy  <= 1'b0;
                  r_table_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RUN: begin
               if (build_start) begin
                  r_state       <= S_BUILD;
                  r_cnt         <= '0;
                  r_build_busy  <= 1'b1;
                  r_table_ready <= 1'b0;
                  r_knot_err    <= 1'b0;
               end else if (w_knot_wr_ok) begin
                  r_state       <= S_IDLE;
                  r_table_ready <= 1'b0;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_build_busy  <= 1'b0;
               r_table_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i <= NSEG; i++)
            r_knot[i] <= '0;
      end else if (w_knot_wr_ok) begin
         r_knot[knot_addr] <= knot_data;
      end
   end

   // Issue index travels alongside the generator latency so each delta lands in its own slot.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NSEG; i++)
            r_slope[i] <= '0;
         for (int unsigned i = 0; i < GD_LATENCY; i++) begin
            r_sr_v[i]   <= 1'b0;
            r_sr_idx[i] <= '0;
         end
      end else begin
         r_sr_v[0]   <= w_issue;
         r_sr_idx[0] <= w_iss_idx;
         for (int unsigned i = 1; i < GD_LATENCY; i++) begin
            r_sr_v[i]   <= r_sr_v[i-1];
            r_sr_idx[i] <= r_sr_idx[i-1];
         end
         if ((r_state == S_BUILD) && r_sr_v[GD_LATENCY-1])
            r_slope[r_sr_idx[GD_LATENCY-1]] <= gd_delta;
      end
   end

   assign w_prod = PW'(r_slope[r_s1_seg]) * PW'(r_s1_frac);

`ifdef PWL_ROUND_EN
   assign w_prod_adj = {1'b0, r_s2_prod} + (PW+1)'(2**(DT_D-1));
`else
   assign w_prod_adj = {1'b0, r_s2_prod};
`endif

   assign w_inc = w_prod_adj >> DT_D;
   assign w_sum = {1'b0, r_s2_knot} + (DSIZE+1)'(w_inc);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_s1_v    <= 1'b0;
         r_s1_seg  <= '0;
         r_s1_frac <= '0;
         r_s2_v    <= 1'b0;
         r_s2_knot <= '0;
         r_s2_prod <= '0;
         r_out_v   <= 1'b0;
         r_out_y   <= '0;
      end else begin
         r_s1_v <= w_accept;
         if (w_accept) begin
            r_s1_seg  <= in_x[XW-1 -: SEG_BITS];
            r_s1_frac <= in_x[FW-1:0];
         end
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_knot <= r_knot[{1'b0, r_s1_seg}];
            r_s2_prod <= w_prod;
         end
         r_out_v <= r_s2_v;
         if (r_s2_v)
            r_out_y <= w_sum[DSIZE] ? '1 : w_sum[DSIZE-1:0];
      end
   end

   assign build_busy  = r_build_busy;
   assign table_ready = r_table_ready;
   assign in_ready    = r_table_ready;
   assign knot_err    = r_knot_err;
   assign out_valid   = r_out_v;
   assign out_y       = r_out_y;

endmodule

// File: tb/tb_pwl_slope_table.sv
// Scoreboard bench for pwl_slope_table: arithmetic reference model of knots/slopes, a 2-cycle
// slope-generator stand-in, and a decoupled output monitor.
module tb_pwl_slope_table;
   logic        clock = 1'b0;
   logic        rst;
   logic        knot_wr;
   logic [4:0]  knot_addr;
   logic [15:0] knot_data;
   logic        build_start;
   logic        build_busy;
   logic        table_ready;
   logic        knot_err;
   logic [15:0] gd_y_disp;
   logic [11:0] gd_delta;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_x;
   logic        out_valid;
   logic [15:0] out_y;

   pwl_slope_table #(.XW(8), .SEG_BITS(4), .DSIZE(16), .DT_I(8), .DT_D(4), .GD_LATENCY(2)) dut (
      .clock(clock), .rst(rst), .knot_wr(knot_wr), .knot_addr(knot_addr), .knot_data(knot_data),
      .build_start(build_start), .build_busy(build_busy), .table_ready(table_ready),
      .knot_err(knot_err), .gd_y_disp(gd_y_disp), .gd_delta(gd_delta), .in_valid(in_valid),
      .in_ready(in_ready), .in_x(in_x), .out_valid(out_valid), .out_y(out_y)
   );

   always #5 clock = ~clock;

   // Slope generator over a 16-step segment: delta in 8.4 units equals the displacement, capped.
   logic [15:0] g_s0;
   logic [11:0] g_s1;
   always @(posedge clock) begin
      g_s0 <= gd_y_disp;
      g_s1 <= (g_s0 > 16'd4095) ? 12'hFFF : g_s0[11:0];
   end
   assign gd_delta = g_s1;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct { int unsigned y; int unsigned due; } exp_t;
   exp_t        q[$];
   int          n_checks = 0;
   int          n_err = 0;
   int unsigned m_knot [17];
   int unsigned m_slope [16];
   bit          m_err;
   int unsigned last_y = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int unsigned m_disp(input int k);
      return (m_knot[k+1] >= m_knot[k]) ? m_knot[k+1] - m_knot[k] : 0;
   endfunction

   function automatic int unsigned model_y(input int unsigned x);
      int unsigned seg  = x / 16;
      int unsigned frac = x % 16;
      int unsigned prod = m_slope[seg] * frac;
      int unsigned y;
`ifdef PWL_ROUND_EN
      prod = prod + 8;
`endif
      y = m_knot[seg] + prod / 16;
      return (y > 65535) ? 65535 : y;
   endfunction

   task automatic reset_model();
      for (int k = 0; k < 17; k++) m_knot[k] = 0;
      for (int k = 0; k < 16; k++) m_slope[k] = 0;
      m_err = 0;
   endtask

   task automatic write_knot(input int a, input int unsigned d);
      knot_wr = 1'b1; knot_addr = 5'(a); knot_data = 16'(d);
      tick();
      knot_wr = 1'b0;
      if (a <= 16) m_knot[a] = d;
   endtask

   task automatic drive_sample(input int unsigned x);
      exp_t e;
      in_valid = 1'b1; in_x = 8'(x);
      check("in_ready", in_ready, 1);
      e.y = model_y(x); e.due = cyc + 3;
      q.push_back(e);
   endtask

   task automatic do_build(input int wr_at, input int wr_addr, input int unsigned wr_data,
                           input int bs_at, input int rst_at);
      int cnt = 0;
      m_err = 0;
      for (int k = 0; k < 16; k++) if (m_knot[k+1] < m_knot[k]) m_err = 1;
      build_start = 1'b1;
      tick();
      build_start = 1'b0;
      while (build_busy === 1'b1 && cnt < 40) begin
         if (cnt == rst_at) begin
            knot_wr = 1'b0; build_start = 1'b0;
            rst = 1'b1;
            #1;
            check("rst_busy", build_busy, 0);
            check("rst_ready", table_ready, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_err", knot_err, 0);
            check("rst_disp", gd_y_disp, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_y", out_y, 0);
            reset_model();
            tick();
            rst = 1'b0;
            tick();
            return;
         end
         if (cnt < 16) check("gd_y_disp", gd_y_disp, m_disp(cnt));
         else          check("gd_y_disp_idle", gd_y_disp, 0);
         knot_wr = (cnt == wr_at); knot_addr = 5'(wr_addr); knot_data = 16'(wr_data);
         build_start = (cnt == bs_at);
         cnt++;
         tick();
      end
      knot_wr = 1'b0; build_start = 1'b0;
      check("busy_len", cnt, 18);
      check("table_ready", table_ready, 1);
      check("knot_err", knot_err, m_err);
      for (int k = 0; k < 16; k++) m_slope[k] = (m_disp(k) > 4095) ? 4095 : m_disp(k);
   endtask

   task automatic random_knots();
      int unsigned v = $urandom_range(2000, 0);
      for (int k = 0; k <= 16; k++) begin
         write_knot(k, v);
         if ($urandom_range(7, 0) == 0) v = (v > 3000) ? v - $urandom_range(3000, 1) : v;
         else                           v = v + $urandom_range(6000, 0);
         if (v > 65535) v = 65535;
      end
   endtask

   task automatic random_stream(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(3, 0) != 0) drive_sample($urandom_range(255, 0));
         else in_valid = 1'b0;
         tick();
      end
      in_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (rst) begin
            last_y = 0;
         end else if (out_valid) begin
            if (q.size() == 0) begin
               n_checks++; n_err++;
               $display("FAIL out_unexpected: got out_y=%0d with no sample pending", out_y);
            end else begin
               e = q.pop_front();
               check("out_y", out_y, e.y);
               check("out_latency", cyc, e.due);
               last_y = e.y;
            end
         end else begin
            check("out_hold", out_y, last_y);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      n_err++;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst = 1'b1; knot_wr = 1'b0; knot_addr = '0; knot_data = '0;
      build_start = 1'b0; in_valid = 1'b0; in_x = '0;
      reset_model();
      tick(); tick(); tick();
      check("reset_busy", build_busy, 0);
      check("reset_ready", table_ready, 0);
      check("reset_err", knot_err, 0);
      check("reset_disp", gd_y_disp, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_y", out_y, 0);
      rst = 1'b0;
      tick();

      // Samples offered while idle must not be accepted.
      in_valid = 1'b1; in_x = 8'h25;
      tick();
      check("idle_in_ready", in_ready, 0);
      tick();
      in_valid = 1'b0;

      for (int k = 0; k <= 16; k++) write_knot(k, 256 * k);
      do_build(-1, 0, 0, -1, -1);
      for (int k = 0; k < 16; k++) check("linear_slope", m_slope[k], 256);
      drive_sample(8'h25); tick(); in_valid = 1'b0;
      check("linear_0x25", model_y(8'h25), 592);
      drive_sample(8'h00); tick();
      drive_sample(8'hFF); tick();
      drive_sample(8'h10); tick();
      in_valid = 1'b0;

      write_knot(20, 16'h1234);
      check("oob_write_keeps_ready", table_ready, 1);

      write_knot(4, 16'h1000);
      write_knot(5, 16'h3000);
      do_build(-1, 0, 0, -1, -1);
      drive_sample(8'h4F); tick(); in_valid = 1'b0;
      check("sat_0x4F", model_y(8'h4F), 16'h1EFF);

      for (int k = 0; k <= 16; k++) write_knot(k, 256 * k);
      write_knot(3, 500);
      write_knot(2, 600);
      write_knot(0, 1000);
      write_knot(1, 1024);
      do_build(3, 9, 16'hABCD, 10, -1);
      drive_sample(8'h2A); tick();
      drive_sample(8'h0B); tick();
      drive_sample(8'h95); tick();
      drive_sample(8'h8F); tick();
      in_valid = 1'b0;
      check("nonmono_0x2A", model_y(8'h2A), 600);

      drive_sample(8'h37); tick();
      in_valid = 1'b0;
      write_knot(6, 9999);
      check("inval_ready", table_ready, 0);
      check("inval_in_ready", in_ready, 0);
      tick(); tick(); tick();

      random_knots();
      do_build(-1, 0, 0, -1, 7);
      check("post_rst_ready", table_ready, 0);

      for (int r = 0; r < 3; r++) begin
         random_knots();
         do_build(-1, 0, 0, -1, -1);
         random_stream(120);
      end

      repeat (8) tick();
      check("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/pwl_slope_table.md
Name: pwl_slope_table

Overview:
- Piecewise-linear interpolator for the rgb-lab nonlinear transfer stage (e.g. f(t) curve on 8-bit channels).
- Holds NSEG+1 knot values and walks consecutive knot pairs through the downstream slope generator: drives y_displacement out, captures the 8.4 delta back.
- Stores one slope per segment, then serves a pipelined stream of x samples: y = knot[seg] + delta*frac.

Parameters:
- XW, 8, input sample width.
- SEG_BITS, 4, log2 of segment count; NSEG = 2**SEG_BITS; segment length = 2**(XW-SEG_BITS) (=16, matches slope generator X_DISPLACEMENT).
- DSIZE, 16, knot/output width.
- DT_I, 8, integer bits of delta.
- DT_D, 4, fraction bits of delta.
- GD_LATENCY, 2, clocks from gd_y_disp sampled to gd_delta valid.

Ports:
- clock  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- knot_wr  in  1  knot write strobe
- knot_addr  in  SEG_BITS+1  knot index 0..NSEG
- knot_data  in  DSIZE  knot value
- build_start  in  1  single-cycle pulse: compute slope table
- build_busy  out  1  high during BUILD
- table_ready  out  1  slope table valid; stream accepted
- knot_err  out  1  sticky: a decreasing knot pair was found in the last build
- gd_y_disp  out  DSIZE  displacement to slope generator
- gd_delta  in  DT_I+DT_D  slope from slope generator
- in_valid  in  1  sample valid
- in_ready  out  1  = table_ready
- in_x  in  XW  sample
- out_valid  out  1  result valid
- out_y  out  DSIZE  interpolated result

Behaviour:
- Reset, asynchronous: state IDLE, all knots 0, all slopes 0, all outputs 0.
- States:
  - IDLE: table_ready=0.
  - BUILD: build_busy=1.
  - RUN: table_ready=1.
- Transitions:
  - IDLE --build_start--> BUILD.
  - BUILD --last capture--> RUN.
  - RUN --build_start--> BUILD.
  - RUN --knot_wr--> IDLE.
- Knot writes:
  - Accepted in IDLE and RUN (in RUN the table is invalidated).
  - Ignored during BUILD.
  - knot_addr > NSEG is ignored.
- build_start:
  - Ignored during BUILD.
  - Simultaneous knot_wr and build_start in IDLE/RUN: write takes effect first, then BUILD.
- BUILD issue sequence:
  - Issue index k = 0..NSEG-1, one per cycle.
  - gd_y_disp = knot[k+1]-knot[k] when knot[k+1] >= knot[k].
  - Otherwise gd_y_disp = 0 and knot_err is set.
  - knot_err clears on entry to BUILD.
- BUILD capture:
  - Delta for index k is captured into slope[k] GD_LATENCY cycles after issue, via a delayed index/valid shift register.
  - BUILD lasts NSEG+GD_LATENCY cycles (18 at default).
  - gd_y_disp = 0 outside issue cycles.
- Stream, accepted on in_valid & in_ready:
  - seg = in_x[XW-1 -: SEG_BITS], frac = in_x[XW-SEG_BITS-1:0].
- Pipeline stages (latency 3, one sample per cycle):
  - S1: register seg and frac.
  - S2: read knot[seg], slope[seg]; product = slope*frac (DT_I+DT_D+XW-SEG_BITS bits).
  - S3: inc = product >> DT_D; sum = knot + inc.
- Output saturation: out_y = all-ones if sum exceeds DSIZE bits, else sum.
- out_valid tracks accepted samples. There is no backpressure; consumer must always sink.
- Samples already in flight when state leaves RUN complete with their captured operands.
- out_y holds its last value when out_valid=0.
- Reset mid-BUILD: table_ready=0, the build aborts, and a new build_start is required.

Optional Feature:
- PWL_ROUND_EN defined: S3 adds 2**(DT_D-1) to product before the shift (round half up). The output saturation guard still applies.
- Undefined: truncation.

Test Plan:
- Linear table:
  - knot[k]=256*k for k=0..16, build_start -> build_busy high 18 cycles, gd_y_disp=256 each issue, every slope=0x100, table_ready=1.
  - Then in_x=0x25 -> out_y=592, 3 cycles after acceptance.
- Back-to-back stream on the linear table:
  - in_x=0x00,0xFF,0x10 on consecutive cycles -> out_y=0,4080,256 on consecutive cycles.
- Saturated slope:
  - knot[4]=0x1000, knot[5]=0x3000 (disp 0x2000) -> slope[4]=0xFFF.
  - in_x=0x4F -> out_y=0x1000+3839=0x1EFF.
- Non-monotonic knots:
  - knot[3]=500, knot[2]=600 -> knot_err=1 after build, gd_y_disp=0 for k=2.
  - in_x=0x2A -> out_y=600.
- Table invalidation and blocking:
  - knot_wr during RUN -> table_ready=0 next cycle, in_ready=0; a sample accepted the cycle before still outputs.
  - knot_wr during BUILD -> knot unchanged.
- Reset mid-BUILD:
  - rst asserted at issue k=7 -> all outputs 0 immediately, state IDLE.
  - After a new build, results match the expected table.
  - With PWL_ROUND_EN, slope 0x018, frac 11 -> inc 17 (vs 16 truncated).
